// File: rtl/score_display_mux.sv
// Multi-digit seven-segment score driver: a sequential double-dabble converts the
// binary score to BCD, and a refresh scanner multiplexes the digits onto one bus.
module score_display_mux #(
   parameter int DIGITS      = 4,
   parameter int VAL_W       = 14,
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_LZ    = 1
) (
   input  logic              pclk,
   input  logic              rst,
   input  logic [VAL_W-1:0]  value,
   input  logic              load,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an,
   output logic              busy,
   output logic              overflow
);

   localparam int BCD_W  = 4 * DIGITS;
   localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int STEP_W = $clog2(VAL_W + 1);

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(VAL_W - 1);

   localparam logic [6:0] SEG_ZERO  = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   typedef enum logic {IDLE, CONV} state_t;

   state_t             stateQ, stateD;
   logic [VAL_W-1:0]   shiftQ, shiftD;
   logic [BCD_W-1:0]   bcdQ, bcdD;
   logic               ovfScratchQ, ovfScratchD;
   logic [STEP_W-1:0]  stepQ, stepD;
   logic               pendingQ, pendingD;
   logic [VAL_W-1:0]   pendValQ, pendValD;
   logic [BCD_W-1:0]   dispQ, dispD;
   logic               ovfQ, ovfD;
   logic               busyQ, busyD;

   logic [CNT_W-1:0]   cntQ, cntD;
   logic [IDX_W-1:0]   idxQ, idxD;
   logic [6:0]         segQ, segD;
   logic [DIGITS-1:0]  anQ, anD;

   logic [BCD_W-1:0]   bcdAdj;
   logic [BCD_W-1:0]   bcdStep;
   logic               carryOut;
   logic               startConv;
   logic [VAL_W-1:0]   startVal;
   logic [BCD_W-1:0]   upperDigits;
   logic               blankDigit;

   function automatic logic [6:0] decodeDigit(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // One double-dabble step: add-3 correction on every nibble, then shift in the value MSB.
   always_comb begin
      bcdAdj = bcdQ;
      for (int k = 0; k < DIGITS; k++) begin
         if (bcdQ[4*k +: 4] >= 4'd5) begin
            bcdAdj[4*k +: 4] = bcdQ[4*k +: 4] + 4'd3;
         end
      end
      bcdStep  = {bcdAdj[BCD_W-2:0], shiftQ[VAL_W-1]};
      carryOut = bcdAdj[BCD_W-1];
   end

   always_comb begin
      stateD      = stateQ;
      shiftD      = shiftQ;
      bcdD        = bcdQ;
      ovfScratchD = ovfScratchQ;
      stepD       = stepQ;
      pendingD    = pendingQ;
      pendValD    = pendValQ;
      dispD       = dispQ;
      ovfD        = ovfQ;
      busyD       = busyQ;
      startConv   = 1'b0;
      startVal    = value;

      case (stateQ)
         IDLE: begin
            if (load) begin
               startConv = 1'b1;
            end
         end
         CONV: begin
            shiftD      = {shiftQ[VAL_W-2:0], 1'b0};
            bcdD        = bcdStep;
            ovfScratchD = ovfScratchQ | carryOut;
            stepD       = stepQ + 1'b1;
            if (load) begin
               pendingD = 1'b1;
               pendValD = value;
            end
            // A load on the completion edge goes straight in, overriding any older pending value.
            if (stepQ == STEP_LAST) begin
               dispD    = bcdStep;
               ovfD     = ovfScratchQ | carryOut;
               pendingD = 1'b0;
               if (load || pendingQ) begin
                  startConv = 1'b1;
                  startVal  = load ? value : pendValQ;
               end else begin
                  stateD = IDLE;
                  busyD  = 1'b0;
               end
            end
         end
         default: begin
            stateD = IDLE;
         end
      endcase

      if (startConv) begin
         stateD      = CONV;
         shiftD      = startVal;
         bcdD        = '0;
         ovfScratchD = 1'b0;
         stepD       = '0;
         busyD       = 1'b1;
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         stateQ      <= IDLE;
         shiftQ      <= '0;
         bcdQ        <= '0;
         ovfScratchQ <= 1'b0;
         stepQ       <= '0;
         pendingQ    <= 1'b0;
         pendValQ    <= '0;
         dispQ       <= '0;
         ovfQ        <= 1'b0;
         busyQ       <= 1'b0;
      end else begin
         stateQ      <= stateD;
         shiftQ      <= shiftD;
         bcdQ        <= bcdD;
         ovfScratchQ <= ovfScratchD;
         stepQ       <= stepD;
         pendingQ    <= pendingD;
         pendValQ    <= pendValD;
         dispQ       <= dispD;
         ovfQ        <= ovfD;
         busyQ       <= busyD;
      end
   end

   // Digits at or above the current one are all zero exactly when the shifted register is zero.
   always_comb begin
      cntD = cntQ + 1'b1;
      idxD = idxQ;
      if (cntQ == CNT_LAST) begin
         cntD = '0;
         idxD = (idxQ == IDX_LAST) ? '0 : idxQ + 1'b1;
      end

      upperDigits = dispQ >> {idxQ, 2'b00};
      blankDigit  = (BLANK_LZ != 0) && (idxQ != '0) && (upperDigits == '0);

      if (ovfQ) begin
         segD = SEG_DASH;
      end else if (blankDigit) begin
         segD = SEG_BLANK;
      end else begin
         segD = decodeDigit(upperDigits[3:0]);
      end
      anD = ~(DIGITS'(1) << idxQ);
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         cntQ <= '0;
         idxQ <= '0;
         segQ <= SEG_ZERO;
         anQ  <= ~(DIGITS'(1));
      end else begin
         cntQ <= cntD;
         idxQ <= idxD;
         segQ <= segD;
         anQ  <= anD;
      end
   end

   assign seg      = segQ;
   assign an       = anQ;
   assign busy     = busyQ;
   assign overflow = ovfQ;

endmodule

// File: tb/tb_score_display_mux.sv
// Self-checking bench for score_display_mux: a transaction-level decimal model is
// compared every cycle, plus literal digit checks for the hand-worked scenarios.
module tb_score_display_mux;

   localparam int DIGITS      = 4;
   localparam int VAL_W       = 14;
   localparam int REFRESH_DIV = 4;
   localparam int BLANK_LZ    = 1;
   localparam int LIMIT       = 10 ** DIGITS;

   logic              pclk  = 1'b0;
   logic              rst   = 1'b1;
   logic              load  = 1'b0;
   logic [VAL_W-1:0]  value = '0;
   logic [6:0]        seg;
   logic [DIGITS-1:0] an;
   logic              busy;
   logic              overflow;

   int checks   = 0;
   int failures = 0;

   score_display_mux #(
      .DIGITS      (DIGITS),
      .VAL_W       (VAL_W),
      .REFRESH_DIV (REFRESH_DIV),
      .BLANK_LZ    (BLANK_LZ)
   ) dut (
      .pclk     (pclk),
      .rst      (rst),
      .value    (value),
      .load     (load),
      .seg      (seg),
      .an       (an),
      .busy     (busy),
      .overflow (overflow)
   );

   always #5 pclk = ~pclk;

   // Reference model state: the display is held as a plain integer, not BCD.
   int         mIdx     = 0;
   int         mCnt     = 0;
   int         mDispVal = 0;
   int         mConvVal = 0;
   int         mLeft    = 0;
   int         mPendVal = 0;
   bit         mOvf     = 1'b0;
   bit         mActive  = 1'b0;
   bit         mPend    = 1'b0;
   logic [6:0] expSeg   = 7'b1000000;
   logic [3:0] expAn    = 4'b1110;
   logic       expBusy  = 1'b0;
   logic       expOvf   = 1'b0;
   bit         modelLive = 1'b0;

   function automatic logic [6:0] digitSeg(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [6:0] modelSeg(input int dispVal, input bit ovf, input int idx);
      int p = 1;
      for (int k = 0; k < idx; k++) p = p * 10;
      if (ovf) return 7'b0111111;
      if (BLANK_LZ != 0 && idx > 0 && dispVal < p) return 7'b1111111;
      return digitSeg((dispVal / p) % 10);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Model updates at each edge: outputs registered from the pre-edge scan position and display.
   always @(posedge pclk or posedge rst) begin
      if (rst) begin
         mIdx = 0; mCnt = 0; mDispVal = 0; mOvf = 1'b0;
         mActive = 1'b0; mPend = 1'b0; mLeft = 0;
         expSeg = 7'b1000000; expAn = 4'b1110; expBusy = 1'b0; expOvf = 1'b0;
      end else begin
         expSeg = modelSeg(mDispVal, mOvf, mIdx);
         expAn  = ~(4'(1) << mIdx);
         if (mActive) begin
            mLeft--;
            if (load) begin
               mPend    = 1'b1;
               mPendVal = int'(value);
            end
            if (mLeft == 0) begin
               mDispVal = mConvVal % LIMIT;
               mOvf     = (mConvVal >= LIMIT);
               if (mPend) begin
                  mConvVal = mPendVal;
                  mLeft    = VAL_W;
                  mPend    = 1'b0;
               end else begin
                  mActive = 1'b0;
               end
            end
         end else if (load) begin
            mActive  = 1'b1;
            mLeft    = VAL_W;
            mConvVal = int'(value);
         end
         expBusy = mActive;
         expOvf  = mOvf;
         if (mCnt == REFRESH_DIV - 1) begin
            mCnt = 0;
            mIdx = (mIdx + 1) % DIGITS;
         end else begin
            mCnt++;
         end
      end
   end

   always @(negedge pclk) begin
      if (modelLive && !rst) begin
         checkOutput("seg", {25'd0, seg}, {25'd0, expSeg});
         checkOutput("an", {28'd0, an}, {28'd0, expAn});
         checkOutput("busy", {31'd0, busy}, {31'd0, expBusy});
         checkOutput("overflow", {31'd0, overflow}, {31'd0, expOvf});
      end
   end

   task automatic applyStimulus(input int v);
      value = VAL_W'(v);
      load  = 1'b1;
      @(negedge pclk);
      load  = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge pclk);
   endtask

   task automatic waitIdle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge pclk);
         n++;
      end
      checkOutput("idle_wait", {31'd0, busy}, 32'd0);
      @(negedge pclk);
   endtask

   task automatic checkDigit(input string name, input int idx, input logic [6:0] lit);
      logic [3:0] pat;
      int n = 0;
      pat = ~(4'(1) << idx);
      while (an !== pat && n < 40) begin
         @(negedge pclk);
         n++;
      end
      checkOutput({name, "_an"}, {28'd0, an}, {28'd0, pat});
      checkOutput(name, {25'd0, seg}, {25'd0, lit});
   endtask

   initial begin
      int n;
      #12;
      checkOutput("rst_seg", {25'd0, seg}, 32'h40);
      checkOutput("rst_an", {28'd0, an}, 32'he);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_ovf", {31'd0, overflow}, 32'd0);
      @(negedge pclk);
      rst = 1'b0;
      modelLive = 1'b1;
      waitCycles(3);

      applyStimulus(1234);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge pclk);
      end
      checkOutput("busy_len", n, 32'd14);
      waitIdle();
      checkDigit("v1234_d0", 0, 7'b0011001);
      checkDigit("v1234_d1", 1, 7'b0110000);
      checkDigit("v1234_d2", 2, 7'b0100100);
      checkDigit("v1234_d3", 3, 7'b1111001);

      applyStimulus(7);
      waitIdle();
      checkDigit("v7_d0", 0, 7'b1111000);
      checkDigit("v7_d1", 1, 7'b1111111);
      checkDigit("v7_d2", 2, 7'b1111111);
      checkDigit("v7_d3", 3, 7'b1111111);
      checkOutput("v7_ovf", {31'd0, overflow}, 32'd0);

      applyStimulus(12345);
      waitIdle();
      checkOutput("v12345_ovf", {31'd0, overflow}, 32'd1);
      for (int d = 0; d < DIGITS; d++) checkDigit("v12345_dash", d, 7'b0111111);

      applyStimulus(0);
      waitIdle();
      checkOutput("v0_ovf", {31'd0, overflow}, 32'd0);
      checkDigit("v0_d0", 0, 7'b1000000);
      checkDigit("v0_d1", 1, 7'b1111111);

      applyStimulus(100);
      waitCycles(3);
      applyStimulus(200);
      waitCycles(3);
      applyStimulus(300);
      waitIdle();
      checkDigit("v300_d0", 0, 7'b1000000);
      checkDigit("v300_d1", 1, 7'b1000000);
      checkDigit("v300_d2", 2, 7'b0110000);
      checkDigit("v300_d3", 3, 7'b1111111);

      applyStimulus(55);
      waitCycles(13);
      applyStimulus(66);
      checkOutput("busy_nogap", {31'd0, busy}, 32'd1);
      waitIdle();
      checkDigit("v66_d0", 0, 7'b0000010);
      checkDigit("v66_d1", 1, 7'b0000010);
      checkDigit("v66_d2", 2, 7'b1111111);
      checkDigit("v66_d3", 3, 7'b1111111);

      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) applyStimulus(int'($urandom_range(0, 99)));
         else applyStimulus(int'($urandom_range(0, (1 << VAL_W) - 1)));
         waitCycles(int'($urandom_range(0, 20)));
      end
      waitIdle();
      waitCycles(20);

      applyStimulus(9999);
      waitCycles(5);
      #2 rst = 1'b1;
      #1;
      checkOutput("arst_seg", {25'd0, seg}, 32'h40);
      checkOutput("arst_an", {28'd0, an}, 32'he);
      checkOutput("arst_busy", {31'd0, busy}, 32'd0);
      checkOutput("arst_ovf", {31'd0, overflow}, 32'd0);
      @(negedge pclk);
      rst = 1'b0;
      waitCycles(20);
      checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
      checkDigit("post_rst_d0", 0, 7'b1000000);
      checkDigit("post_rst_d1", 1, 7'b1111111);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
